// File: rtl/mgc_ace_snoop_arbiter.sv
// -----------------------------------------------------------------------------
// mgc_ace_snoop_arbiter
//
// Shares one ACE snoop address (AC) channel among NUM_REQ snoop requesters.
// Round-robin arbitration. A request is blocked while its cache line is held
// by any snoop still in flight. The number of snoops in flight is limited by
// MAX_OUTSTANDING. Snoop responses (CR) come back in order. Each response is
// routed to the requester that issued the matching snoop.
//
// Ports
//   ACLK, ARESET           clock; synchronous active-high reset
//   req_valid/addr/snoop   per-requester snoop requests (packed buses)
//   req_ready              one-hot combinational grant
//   rsp_valid/rsp_resp     one-cycle one-hot response pulse with its CRRESP
//   AC*                    snoop address channel toward the slave BFM
//   CR*                    snoop response channel from the slave BFM
//   outstanding            number of tracker entries in use
//
// Handshake semantics (all channels): a transfer occurs on a rising edge
// where valid and ready are both high. The source holds valid and the payload
// stable until that edge. Ready may depend combinationally on valid.
// -----------------------------------------------------------------------------
module mgc_ace_snoop_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CACHE_LINE_SIZE = 7,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0]          req_snoop,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [4:0]                    rsp_resp,
    output logic                          ACVALID,
    input  logic                          ACREADY,
    output logic [ADDR_WIDTH-1:0]         ACADDR,
    output logic [3:0]                    ACSNOOP,
    output logic [2:0]                    ACPROT,
    input  logic                          CRVALID,
    output logic                          CRREADY,
    input  logic [4:0]                    CRRESP,
    output logic [CW-1:0]                 outstanding
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int LW = ADDR_WIDTH - CACHE_LINE_SIZE;

    typedef enum logic {AC_IDLE, AC_ISSUE} ac_state_e;

    // Tracker: a circular FIFO with one entry per snoop in flight.
    logic          ent_vld_q  [MAX_OUTSTANDING], ent_vld_d  [MAX_OUTSTANDING];
    logic          ent_iss_q  [MAX_OUTSTANDING], ent_iss_d  [MAX_OUTSTANDING];
    logic [IW-1:0] ent_id_q   [MAX_OUTSTANDING], ent_id_d   [MAX_OUTSTANDING];
    logic [LW-1:0] ent_line_q [MAX_OUTSTANDING], ent_line_d [MAX_OUTSTANDING];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    ac_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0] acaddr_q, acaddr_d;
    logic [3:0]      acsnoop_q, acsnoop_d;
    logic [PW-1:0]   ac_idx_q, ac_idx_d;     // tracker entry currently on AC
    logic [IW-1:0]   rr_q, rr_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [4:0]      rsp_resp_q, rsp_resp_d;

    logic [LW-1:0]   req_line [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic            gnt_found, grant, ac_hs, cr_hs, can_grant;
    logic [IW-1:0]   gnt_idx;
    int              j;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ACVALID     = (state_q == AC_ISSUE);
    assign ACADDR      = acaddr_q;
    assign ACSNOOP     = acsnoop_q;
    assign ACPROT      = 3'b000;
    assign CRREADY     = ent_vld_q[head_q] && ent_iss_q[head_q];
    assign rsp_valid   = rsp_valid_q;
    assign rsp_resp    = rsp_resp_q;
    assign outstanding = count_q;

    always_comb begin
        req_ready = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        ac_hs     = ACVALID && ACREADY;
        cr_hs     = CRVALID && CRREADY;
        // Count and hazards use the registered state. A pop in this cycle
        // frees its slot and its line only from the next cycle.
        can_grant = !ARESET && (count_q < CW'(MAX_OUTSTANDING)) && (!ACVALID || ACREADY);

        for (int i = 0; i < NUM_REQ; i++) begin
            req_line[i] = req_addr[i*ADDR_WIDTH+CACHE_LINE_SIZE +: LW];
            elig[i]     = req_valid[i];
            for (int e = 0; e < MAX_OUTSTANDING; e++) begin
                if (ent_vld_q[e] && (ent_line_q[e] == req_line[i])) elig[i] = 1'b0;
            end
        end

        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!gnt_found && elig[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
        grant = can_grant && gnt_found;
        if (grant) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        ent_vld_d   = ent_vld_q;
        ent_iss_d   = ent_iss_q;
        ent_id_d    = ent_id_q;
        ent_line_d  = ent_line_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q + CW'(grant) - CW'(cr_hs);
        state_d     = state_q;
        acaddr_d    = acaddr_q;
        acsnoop_d   = acsnoop_q;
        ac_idx_d    = ac_idx_q;
        rr_d        = rr_q;
        rsp_valid_d = '0;
        rsp_resp_d  = '0;

        // The granted entry always lands in a free slot, so it never aliases
        // the entry being issued or popped in the same cycle.
        if (ac_hs) ent_iss_d[ac_idx_q] = 1'b1;

        if (grant) begin
            ent_vld_d[tail_q]  = 1'b1;
            ent_iss_d[tail_q]  = 1'b0;
            ent_id_d[tail_q]   = gnt_idx;
            ent_line_d[tail_q] = req_line[gnt_idx];
            tail_d             = ptr_inc(tail_q);
            acaddr_d           = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            acsnoop_d          = req_snoop[gnt_idx*4 +: 4];
            ac_idx_d           = tail_q;
            state_d            = AC_ISSUE;
            rr_d               = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (ac_hs) begin
            state_d = AC_IDLE;
        end

        if (cr_hs) begin
            ent_vld_d[head_q]             = 1'b0;
            head_d                        = ptr_inc(head_q);
            rsp_valid_d[ent_id_q[head_q]] = 1'b1;
            rsp_resp_d                    = CRRESP;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int e = 0; e < MAX_OUTSTANDING; e++) begin
                ent_vld_q[e]  <= 1'b0;
                ent_iss_q[e]  <= 1'b0;
                ent_id_q[e]   <= '0;
                ent_line_q[e] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            state_q     <= AC_IDLE;
            acaddr_q    <= '0;
            acsnoop_q   <= '0;
            ac_idx_q    <= '0;
            rr_q        <= '0;
            rsp_valid_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            ent_vld_q   <= ent_vld_d;
            ent_iss_q   <= ent_iss_d;
            ent_id_q    <= ent_id_d;
            ent_line_q  <= ent_line_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            state_q     <= state_d;
            acaddr_q    <= acaddr_d;
            acsnoop_q   <= acsnoop_d;
            ac_idx_q    <= ac_idx_d;
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end
endmodule
